// File: rtl/pixel_pkg.sv
// Shared types and gray-conversion helpers for the pixel window buffer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pixel_pkg;

    typedef logic [23:0]      rgb_t;
    typedef logic [7:0]       gray_t;
    typedef logic [8:0][7:0]  window_t;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } win_state_t;

    // First row/column index that has a full 3x3 neighbourhood behind it
    localparam int EDGE_SKIP = 2;

    // Cheap luma approximation: (R + 2G + B) / 4 in a 10-bit sum
    function automatic gray_t gray_avg(input rgb_t p);
        logic [9:0] w_sum;
        w_sum = 10'(p[23:16]) + {1'b0, p[15:8], 1'b0} + 10'(p[7:0]);
        return gray_t'(w_sum >> 2);
    endfunction

    // BT.601 weights scaled by 256: (77R + 150G + 29B) / 256 in a 16-bit sum
    function automatic gray_t gray_bt601(input rgb_t p);
        logic [15:0] w_sum;
        w_sum = 16'(p[23:16]) * 16'd77 + 16'(p[15:8]) * 16'd150 + 16'(p[7:0]) * 16'd29;
        return gray_t'(w_sum >> 8);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of gray pixels as a shift-enable register chain.
// Latency: o_dout is the sample pushed DEPTH enables ago.
// Backpressure: none; the chain only moves when i_en is high.
module line_buffer
    import pixel_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic       i_clk,
    input  logic       i_en,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout
);

    gray_t [DEPTH-1:0] r_taps;

    // Shift one sample in per enabled cycle; contents are never reset
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_taps <= {r_taps[DEPTH-2:0], i_din};
        end
    end

    assign o_dout = r_taps[DEPTH-1];

endmodule

// File: rtl/pixel_window_buffer.sv
// Raster RGB to gray, two line buffers, emits a 3x3 window per interior pixel.
// Latency: 1 cycle accept-to-window (2 cycles when PIXEL_WINDOW_BT601_EN is defined).
// Backpressure: pix_ready drops while a window is held unconsumed and during DONE.
module pixel_window_buffer
    import pixel_pkg::*;
#(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int COL_W      = $clog2(IMG_WIDTH),
    parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_rgb,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [71:0] win_data,
    output logic        frame_done
);

    win_state_t          r_state;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic                r_frame_done;
    logic                r_win_valid;
    window_t             r_win_data;
    logic [1:0][7:0]     r_top;
    logic [1:0][7:0]     r_mid;
    logic [1:0][7:0]     r_bot;

    logic                w_out_free;
    logic                w_accept;
    logic                w_col_last;
    logic                w_row_last;
    logic                w_emit_now;
    logic                w_p_vld;
    gray_t               w_p_gray;
    logic                w_p_emit;
    gray_t               w_lb0_out;
    gray_t               w_lb1_out;
    window_t             w_next_win;

    // The output register can take a new window if empty or being drained
    assign w_out_free = !r_win_valid || win_ready;
    // rst forces pix_ready low immediately, not just from the next edge
    assign pix_ready  = !rst && (r_state != DONE) && w_out_free;
    assign w_accept   = pix_valid && pix_ready;
    assign w_col_last = (r_col == COL_W'(IMG_WIDTH - 1));
    assign w_row_last = (r_row == ROW_W'(IMG_HEIGHT - 1));
    assign w_emit_now = (r_row >= ROW_W'(EDGE_SKIP)) && (r_col >= COL_W'(EDGE_SKIP));

`ifdef PIXEL_WINDOW_BT601_EN
    logic  r_s1_vld;
    logic  r_s1_emit;
    gray_t r_s1_gray;
    logic  r_frame_done_d;

    // Register the weighted gray value; the stage moves in step with the output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_emit <= 1'b0;
            r_s1_gray <= '0;
        end else if (clear) begin
            r_s1_vld  <= 1'b0;
        end else if (w_out_free) begin
            r_s1_vld  <= w_accept;
            r_s1_emit <= w_emit_now;
            r_s1_gray <= gray_bt601(pix_rgb);
        end
    end

    // Delay the end-of-frame pulse by the same extra stage as the windows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done_d <= 1'b0;
        end else if (clear) begin
            r_frame_done_d <= 1'b0;
        end else begin
            r_frame_done_d <= r_frame_done;
        end
    end

    assign w_p_vld    = r_s1_vld && w_out_free && !clear;
    assign w_p_gray   = r_s1_gray;
    assign w_p_emit   = r_s1_emit;
    assign frame_done = r_frame_done_d;
`else
    // A clear in the same cycle drops the pixel before it touches the buffers
    assign w_p_vld    = w_accept && !clear;
    assign w_p_gray   = gray_avg(pix_rgb);
    assign w_p_emit   = w_emit_now;
    assign frame_done = r_frame_done;
`endif

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
        .i_clk  (clk),
        .i_en   (w_p_vld),
        .i_din  (w_p_gray),
        .o_dout (w_lb0_out)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .i_clk  (clk),
        .i_en   (w_p_vld),
        .i_din  (w_lb0_out),
        .o_dout (w_lb1_out)
    );

    // Keep the two previous columns of each window row; the third is the incoming one
    always_ff @(posedge clk) begin
        if (w_p_vld) begin
            r_top <= {w_lb1_out, r_top[1]};
            r_mid <= {w_lb0_out, r_mid[1]};
            r_bot <= {w_p_gray,  r_bot[1]};
        end
    end

    // Element [0] is top-left (row r-2, col c-2), [8] is the current pixel
    assign w_next_win = {w_p_gray,  r_bot[1], r_bot[0],
                         w_lb0_out, r_mid[1], r_mid[0],
                         w_lb1_out, r_top[1], r_top[0]};

    // Load a new window when an interior pixel lands, else drain on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            r_win_data  <= '0;
        end else if (clear) begin
            r_win_valid <= 1'b0;
        end else if (w_p_vld && w_p_emit) begin
            r_win_valid <= 1'b1;
            r_win_data  <= w_next_win;
        end else if (win_ready) begin
            r_win_valid <= 1'b0;
        end
    end

    assign win_valid = r_win_valid;
    assign win_data  = r_win_data;

    // Raster position and frame phase; counters zero on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FILL;
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end else if (clear) begin
            r_state      <= FILL;
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                            if (r_row == ROW_W'(EDGE_SKIP - 1)) begin
                                r_state <= RUN;
                            end
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        if (w_col_last && w_row_last) begin
                            r_col        <= '0;
                            r_row        <= '0;
                            r_state      <= DONE;
                            r_frame_done <= 1'b1;
                        end else if (w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_state <= FILL;
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: doc/pixel_window_buffer.md
Name: pixel_window_buffer

Overview:
- Downstream consumer of the pixel controller's SRAM read stream.
- Accepts raster-order 24-bit RGB pixels, reduces each to an 8-bit grayscale value, and keeps two line buffers.
- Emits a 3x3 grayscale neighbourhood per interior pixel to the edge-detection kernel.
- Uses a valid/ready handshake on both sides so SRAM read latency and kernel stalls are absorbed.

Parameters:
- IMG_WIDTH, 32, pixels per row (>=3)
- IMG_HEIGHT, 32, rows per frame (>=3)
- COL_W, $clog2(IMG_WIDTH), column counter width
- ROW_W, $clog2(IMG_HEIGHT), row counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- clear  in  1  synchronous frame restart; zeroes counters and state, keeps buffer contents
- pix_valid  in  1  pix_rgb holds a pixel
- pix_ready  out  1  block accepts a pixel this cycle
- pix_rgb  in  24  {R[23:16],G[15:8],B[7:0]}
- win_valid  out  1  win_data holds a valid window
- win_ready  in  1  kernel consumes window this cycle
- win_data  out  72  [8:0][7:0], row-major; [0]=top-left (row r-2, col c-2), [8]=bottom-right (current pixel)
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset values: pix_ready=0, win_valid=0, win_data=0, frame_done=0, counters=0, state=FILL. Line buffers are not reset.
- Accept condition: pix_valid && pix_ready.
- pix_ready = (state!=DONE) && (!win_valid || win_ready).
- Gray conversion is combinational on the input: g = (R + 2G + B) >> 2, computed in a 10-bit sum, truncated to 8 bits.
- On each accept:
  - g is pushed into line buffer 0; its IMG_WIDTH-old output is pushed into line buffer 1.
  - Three 3-deep column shift registers (rows r-2, r-1, r) shift left.
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
- Window emission: if an accept occurs with row>=2 and col>=2, win_data and win_valid are registered on the next edge. Latency is 1 cycle from accept to win_valid.
- The window holds stable while win_valid && !win_ready. win_valid clears after a handshake with no new window.
- Simultaneous handshake and new accept: the new window replaces the old one and win_valid stays high.
- Columns 0–1 and rows 0–1 never produce windows. Each frame produces exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
- States:
  - FILL: row<2. Moves to RUN when row reaches 2.
  - RUN: moves to DONE on the accept at col=IMG_WIDTH-1, row=IMG_HEIGHT-1.
  - DONE: one cycle. frame_done=1, pix_ready=0, counters reset to 0, then back to FILL.
- The pending window in DONE is still delivered; the handshake is not blocked.
- clear: takes effect next edge from any state. Counters=0, state=FILL, win_valid=0, frame_done=0. clear has priority over an accept in the same cycle, and that pixel is dropped.
- rst mid-frame: all outputs return to their reset values immediately, without waiting for a clock edge.

Optional Feature:
- PIXEL_WINDOW_BT601_EN defined: g = (77R + 150G + 29B) >> 8, computed in a 16-bit sum and registered. Accept-to-win_valid latency becomes 2 cycles, and the frame_done timing shifts identically.
- Undefined: the shift-add formula above with 1-cycle latency.

Decomposition:
- Package pixel_pkg contains:
  - typedef rgb_t (24b) and gray_t (8b)
  - typedef window_t as [8:0][7:0]
  - enum win_state_t {FILL, RUN, DONE}
  - gray-conversion function(s)
- Sub-module line_buffer: parameterised depth IMG_WIDTH, 8-bit, shift-enable register chain. Instantiated twice.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=4; pixel n is sent as RGB {n,n,n}, so gray=n in both modes):
- Stream pixels 0..15 with win_ready=1.
  - First win_valid arrives 1 cycle after pixel 10: win_data = {0,1,2,4,5,6,8,9,10}.
  - Exactly 4 windows total; last = {5,6,7,9,10,11,13,14,15}.
  - frame_done pulses once.
- Hold win_ready=0 after the first window. win_data stays {0,...,10}, pix_ready=0, and no pixel is accepted until win_ready=1.
- Drive RGB {255,255,255} → gray 255. Drive {0,255,0} → 127 with the default formula, 149 under BT601.
- Assert rst after pixel 6, then stream 0..15. Outputs zero while rst is high, and the full window sequence of the first scenario is reproduced.
- Pulse clear concurrently with the accept of pixel 9. Pixel 9 is dropped, no window is emitted, and the next accepted pixel is treated as col 0, row 0.
- Send two frames back to back. 8 windows total, one frame_done per frame, and pix_ready is low exactly one cycle between frames.
